// File: rtl/mem_rd_arbiter_if.sv
// AXI4-Lite read-channel bundle (AR + R).
// One instance per master port and one for the shared slave port.
interface mem_rd_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0] araddr;
   logic              arvalid;
   logic              arready;
   logic [DATA_W-1:0] rdata;
   logic [1:0]        rresp;
   logic              rvalid;
   logic              rready;

   // A beat transfers on a rising edge where valid and ready are both 1.
   // Once valid is raised, it and its payload hold until that edge.
   // Ready may rise or fall freely and may depend on valid.
   modport master (
      output araddr, arvalid, rready,
      input  arready, rdata, rresp, rvalid
   );
   modport slave (
      input  araddr, arvalid, rready,
      output arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/mem_rd_arbiter.sv
// Round-robin IFU/LSU read arbiter in front of one AXI4-Lite read port.
// One read is in flight at a time. New grants wait while an LSU write is outstanding.
module mem_rd_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_pending_i,
   mem_rd_arbiter_if.slave  ifu,
   mem_rd_arbiter_if.slave  lsu,
   mem_rd_arbiter_if.master s,
   output logic [1:0]       state_o,
   output logic             owner_o
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic              owner_q, owner_d;
   logic              last_q, last_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              grant;
   logic              lsu_wins;
   logic              own_rready;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         owner_q <= 1'b0;
         last_q  <= 1'b0;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         addr_q  <= addr_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      last_d     = last_q;
      addr_d     = addr_q;
      // On a tie, the master that did not own the previous read wins.
      lsu_wins   = lsu.arvalid && (!ifu.arvalid || !last_q);
      grant      = (state_q == IDLE) && !wr_pending_i && (ifu.arvalid || lsu.arvalid);
      own_rready = owner_q ? lsu.rready : ifu.rready;
      case (state_q)
         IDLE: begin
            if (grant) begin
               state_d = ADDR;
               owner_d = lsu_wins;
               addr_d  = lsu_wins ? lsu.araddr : ifu.araddr;
            end
         end
         ADDR: begin
            if (s.arready) state_d = DATA;
         end
         DATA: begin
            if (s.rvalid && own_rready) begin
               state_d = IDLE;
               last_d  = owner_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Handshake outputs are held low while reset is asserted.
   assign ifu.arready = rst && grant && !lsu_wins;
   assign lsu.arready = rst && grant && lsu_wins;
   assign s.araddr    = addr_q;
   assign s.arvalid   = rst && (state_q == ADDR);
   assign s.rready    = rst && (state_q == DATA) && own_rready;
   assign ifu.rvalid  = rst && (state_q == DATA) && !owner_q && s.rvalid;
   assign lsu.rvalid  = rst && (state_q == DATA) && owner_q && s.rvalid;
   assign ifu.rdata   = s.rdata;
   assign ifu.rresp   = s.rresp;
   assign lsu.rdata   = s.rdata;
   assign lsu.rresp   = s.rresp;
   assign state_o     = state_q;
   assign owner_o     = owner_q;
endmodule
